fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of register_file's PC port and of the decode stage.
- Reads the architectural PC from register_file.
- Issues a req/ack read to instruction memory.
- Returns the next PC through pc_update/pc_write.
- Drives the IF/ID pipeline register, including a one-entry skid buffer for decode stalls and branch-flush handling.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 51 +++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and types for the ARM fetch pipeline
package arm_pipe_pkg;
    localparam int WORD_W         = 32;
    localparam int PC_INCR        = 4;
    localparam int PC_READ_OFFSET = 8;
    localparam logic [WORD_W-1:0] ARM_NOP = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, pc} holding register for decode stalls
module fetch_skid_buf
    import arm_pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Flush wins over load so a redirect always leaves the buffer empty.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= DATA_W'(ARM_NOP);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage driving the PC and the IF/ID register
module fetch_unit
    import arm_pipe_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_update,
    output logic              pc_write,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus8,
    output logic              if_valid
);
    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus8_q, if_pc_plus8_d;
    logic              if_valid_q, if_valid_d;

    logic              skid_load, skid_flush, skid_valid;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic              accept;

    assign accept = !if_valid_q || !stall;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .flush    (skid_flush),
        .in_instr (imem_rdata),
        .in_pc    (pc),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // PC write-back and memory request are combinational so register_file commits on this edge.
    always_comb begin
        pc_write  = 1'b0;
        pc_update = '0;
        imem_req  = 1'b0;
        imem_addr = '0;
        if (!rst) begin
            if (state_q == BOOT) begin
                pc_write  = 1'b1;
                pc_update = ADDR_W'(RESET_PC);
            end else if (branch_taken) begin
                pc_write  = 1'b1;
                pc_update = branch_target;
            end else if (state_q == REQ && imem_ack) begin
                pc_write  = 1'b1;
                pc_update = pc + ADDR_W'(PC_INCR);
            end
            if (state_q == REQ) begin
                imem_req  = 1'b1;
                imem_addr = pc;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus8_d = if_pc_plus8_q;
        if_valid_d    = if_valid_q;
        skid_load     = 1'b0;
        skid_flush    = 1'b0;
        if (state_q != BOOT && branch_taken) begin
            state_d    = REQ;
            skid_flush = 1'b1;
            if_valid_d = 1'b0;
            if_instr_d = DATA_W'(ARM_NOP);
        end else begin
            case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    if (imem_ack && accept) begin
                        if_instr_d    = imem_rdata;
                        if_pc_d       = pc;
                        if_pc_plus8_d = pc + ADDR_W'(PC_READ_OFFSET);
                        if_valid_d    = 1'b1;
                    end else if (imem_ack) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else if (accept) begin
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall && skid_valid) begin
                        if_instr_d    = skid_instr;
                        if_pc_d       = skid_pc;
                        if_pc_plus8_d = skid_pc + ADDR_W'(PC_READ_OFFSET);
                        if_valid_d    = 1'b1;
                        skid_flush    = 1'b1;
                        state_d       = REQ;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            if_instr_q    <= DATA_W'(ARM_NOP);
            if_pc_q       <= '0;
            if_pc_plus8_q <= '0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus8_q <= if_pc_plus8_d;
            if_valid_q    <= if_valid_d;
        end
    end

    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus8 = if_pc_plus8_q;
    assign if_valid    = if_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit with a behavioural model
module tb_fetch_unit;
    localparam logic [31:0] NOP      = 32'hE1A0_0000;
    localparam logic [31:0] BOOT_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_update, imem_addr, imem_rdata, branch_target;
    logic [31:0] if_instr, if_pc, if_pc_plus8;
    logic        pc_write, imem_req, imem_ack, stall, branch_taken, if_valid;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(BOOT_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_update     (pc_update),
        .pc_write      (pc_write),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus8   (if_pc_plus8),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } ent_t;

    // Model: a boot flag, the architectural PC, a pending-instruction queue and the IF/ID contents.
    logic        m_boot;
    ent_t        pend_q[$];
    logic        m_v;
    logic [31:0] m_i, m_p, m_p8;
    logic [31:0] last_upd;
    int          total = 0;
    int          bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check_val("if_valid", {31'b0, if_valid}, {31'b0, m_v});
        check_val("if_instr", if_instr, m_i);
        check_val("if_pc", if_pc, m_p);
        check_val("if_pc_plus8", if_pc_plus8, m_p8);
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        pend_q.delete();
        m_v  = 1'b0;
        m_i  = NOP;
        m_p  = 32'h0;
        m_p8 = 32'h0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_pc_write", {31'b0, pc_write}, 32'h0);
        check_val("rst_pc_update", pc_update, 32'h0);
        check_val("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check_val("rst_imem_addr", imem_addr, 32'h0);
        check_regs();
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] bt,
                        input logic ak, input logic [31:0] rd);
        logic        ew, er;
        logic [31:0] eu, ea;
        ent_t        e;
        @(negedge clk);
        stall = st; branch_taken = br; branch_target = bt; imem_ack = ak; imem_rdata = rd;
        #1;
        er = !m_boot && pend_q.size() == 0;
        ea = er ? pc : 32'h0;
        if (m_boot)           begin ew = 1'b1; eu = BOOT_PC;  end
        else if (br)          begin ew = 1'b1; eu = bt;       end
        else if (er && ak)    begin ew = 1'b1; eu = pc + 4;   end
        else                  begin ew = 1'b0; eu = 32'h0;    end
        check_val("imem_req", {31'b0, imem_req}, {31'b0, er});
        check_val("imem_addr", imem_addr, ea);
        check_val("pc_write", {31'b0, pc_write}, {31'b0, ew});
        check_val("pc_update", pc_update, eu);
        check_regs();
        last_upd = pc_update;
        @(posedge clk);
        #1;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (br) begin
            pend_q.delete();
            m_v = 1'b0;
            m_i = NOP;
        end else if (pend_q.size() != 0) begin
            if (!st) begin
                e = pend_q.pop_front();
                m_i = e.instr; m_p = e.addr; m_p8 = e.addr + 8; m_v = 1'b1;
            end
        end else if (ak) begin
            if (!m_v || !st) begin
                m_i = rd; m_p = pc; m_p8 = pc + 8; m_v = 1'b1;
            end else begin
                e.instr = rd; e.addr = pc;
                pend_q.push_back(e);
            end
        end else if (!m_v || !st) begin
            m_v = 1'b0;
        end
        if (ew) pc = eu;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; pc = 32'hDEAD_BEE0;
        model_reset();
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Boot, then zero-latency streaming from 0x0.
        step(0, 0, 0, 1, 32'h1111_0000);
        step(0, 0, 0, 1, 32'hE000_0000);
        step(0, 0, 0, 1, 32'hE000_0004);
        step(0, 0, 0, 1, 32'hE000_0008);
        // Three-cycle memory latency.
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'hE3A0_1001);
        // Stall with ack into the skid buffer, then release.
        step(1, 0, 0, 1, 32'hE3A0_2002);
        step(1, 0, 0, 1, 32'hE3A0_3003);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'hE3A0_4004);
        // Branch while holding a skid entry.
        step(1, 0, 0, 1, 32'hE3A0_5005);
        step(1, 1, 32'h0000_0100, 0, 32'h0);
        step(0, 0, 0, 1, 32'hE3A0_6006);
        // Branch coinciding with an ack: acked data must be dropped.
        step(0, 1, 32'h0000_0200, 1, 32'hBAD0_BAD0);
        step(0, 0, 0, 1, 32'hE3A0_7007);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 10) < 3, ($urandom % 10) == 0,
                 (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC),
                 ($urandom % 10) < 6, $urandom);
        end

        // Asynchronous reset in the middle of a pending request.
        step(0, 1, 32'h0000_0040, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 0, 0, 32'h0);
        check_val("boot_pc", pc, BOOT_PC);

        // Address wrap at the top of the space.
        step(0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        step(0, 0, 0, 1, 32'hE1A0_1234);
        check_val("wrap_pc_update", last_upd, 32'h0000_0000);
        check_val("wrap_plus8", if_pc_plus8, 32'h0000_0004);
        step(0, 0, 0, 1, 32'hE1A0_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
